// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, FSM states, widths.
package alu_pkg;

    localparam int DEF_DW  = 32;
    localparam int DEF_OPW = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time
// gets the grant.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    input  logic       i_en,
    output logic [1:0] o_grant,
    output logic       o_winner
);

    always_comb begin
        o_winner = (&i_valid) ? ~i_last : ~i_valid[0];
        o_grant  = 2'b00;
        if (i_en && (|i_valid)) begin
            o_grant = o_winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the EX issue path (port 0) and the
// auxiliary unit (port 1): registered operands, captured result, rsp handshake.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int OPW = DEF_OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [DW-1:0]  rsp_out,
    output logic           rsp_z,
    output logic           rsp_c,
    output logic           rsp_v,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_sel,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_z,
    input  logic           alu_c,
    input  logic           alu_v
);

    arb_state_t     r_state;
    arb_state_t     w_next;
    logic           r_owner;
    logic           r_last;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [OPW-1:0] r_alu_sel;
    logic [DW-1:0]  r_rsp_out;
    logic           r_rsp_z;
    logic           r_rsp_c;
    logic           r_rsp_v;

    logic           w_retire;
    logic           w_accept_ok;
    logic           w_accept;
    logic           w_winner;
    logic [1:0]     w_grant;

    // Gating with rst_n keeps req_ready low while reset is held.
    assign w_retire    = (r_state == ST_RESP) && rsp_ready[r_owner];
    assign w_accept_ok = rst_n && ((r_state == ST_IDLE) || w_retire);
    assign w_accept    = |w_grant;

    rr_arb2 u_arb (
        .i_valid  (req_valid),
        .i_last   (r_last),
        .i_en     (w_accept_ok),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: begin
                if (w_retire) w_next = w_accept ? ST_EXEC : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_rsp_out <= '0;
            r_rsp_z   <= 1'b0;
            r_rsp_c   <= 1'b0;
            r_rsp_v   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner   <= w_winner;
                r_last    <= w_winner;
                r_alu_a   <= w_winner ? req1_a  : req0_a;
                r_alu_b   <= w_winner ? req1_b  : req0_b;
                r_alu_sel <= w_winner ? req1_op : req0_op;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_out <= alu_out;
                r_rsp_z   <= alu_z;
                r_rsp_c   <= alu_c;
                r_rsp_v   <= alu_v;
            end
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (r_state == ST_RESP) rsp_valid[r_owner] = 1'b1;
    end

    assign req_ready = w_grant;
    assign rsp_out   = r_rsp_out;
    assign rsp_z     = r_rsp_z;
    assign rsp_c     = r_rsp_c;
    assign rsp_v     = r_rsp_v;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;

endmodule
